enc4to2_seq: RTL and testbench
==============================

// Module: enc4to2_seq
// PURPOSE
// - Sequential 4-to-2 encoder; the encode-side counterpart of the 2-to-4 decoder.
// - Accepts a 4-bit multi-hot request vector over a valid/ready handshake.
// - Emits one 2-bit index per set bit, one beat per handshake, until every set bit is encoded.
// - Sits between request sources and any consumer that takes 2-bit indices, e.g. the 2-to-4 decoder.
// PARAMETERS
// - MSB_FIRST  0  0: lowest set index emitted first; 1: highest set index emitted first.
// - ZERO_DROP  1  1: zero vector is consumed and emits no beat; 0: zero vector emits one beat, code 2'b00, out_last=1.
// PORTS
// - clk        in   1  single clock, rising edge.
// - rst_n      in   1  reset, asynchronous, active-low.
// - in_valid   in   1  in_vec is valid.
// - in_ready   out  1  block can accept a vector.
// - in_vec     in   4  request vector; bit i set means "emit code i".
// - out_valid  out  1  out_code is valid.
// - out_ready  in   1  consumer accepts out_code.
// - out_code   out  2  encoded index of the currently selected bit.
// - out_last   out  1  current beat is the final beat for this vector.
// - pend_cnt   out  3  set bits still pending, including the current beat (0..4).
// - zero_err   out  1  one-cycle pulse: an all-zero vector was accepted.
// BEHAVIOUR
// Reset
// - All outputs are registered.
// - While rst_n=0: state=IDLE, pending register=0, and in_ready, out_valid, out_code, out_last, pend_cnt, zero_err are all 0.
// - in_ready rises on the first clk edge after rst_n deasserts.
// - Asserting rst_n mid-operation discards pending bits; out_valid drops immediately (asynchronous reset).
// FSM: IDLE, EMIT
// - IDLE: in_ready=1, out_valid=0. Accept on in_valid & in_ready at edge N. Then:
//   - in_vec!=0: latch into pend, go to EMIT. At edge N, in_ready=0; out_valid=1 with the first code in cycle N+1 (1-cycle latency).
//   - in_vec==0 and ZERO_DROP=1: stay in IDLE, zero_err=1 for one cycle, no beat.
//   - in_vec==0 and ZERO_DROP=0: zero_err=1 for one cycle; go to EMIT with a single beat: out_code=0, out_last=1, pend_cnt=1.
// - EMIT: out_valid=1, in_ready=0; in_valid is ignored.
//   - out_code = index of the lowest set pend bit, or the highest when MSB_FIRST=1.
//   - pend_cnt = popcount(pend). out_last = (pend_cnt==1).
//   - out_code, out_last and pend_cnt hold stable while out_valid & !out_ready (no change under backpressure).
//   - On out_valid & out_ready: clear the selected bit. The next code appears the cycle after the edge.
//   - If the beat was out_last: go to IDLE; out_valid=0 and in_ready=1 the cycle after.
// Throughput and ordering
// - A vector with k set bits (k>=1) occupies k EMIT cycles plus 1 IDLE cycle before the next accept, with no backpressure.
// - No back-to-back reload in the same cycle as the last beat.
// - Codes within a vector are strictly monotonic: ascending when MSB_FIRST=0, descending when MSB_FIRST=1.
// - Each set bit is emitted exactly once; no code is emitted for an unset bit except the ZERO_DROP=0 zero beat.
// Simultaneous events
// - in_valid asserted during EMIT is not accepted; the source must hold it until in_ready=1.
// - out_ready asserted while out_valid=0 has no effect.
// TESTING
// - MSB_FIRST=0, in_vec=4'b1011, out_ready=1 -> codes 0,1,3 on 3 consecutive cycles; pend_cnt 3,2,1; out_last only on code 3; in_ready=1 the next cycle.
// - MSB_FIRST=1, in_vec=4'b1011 -> codes 3,1,0; out_last on code 0.
// - in_vec=4'b0100, out_ready=0 for 5 cycles -> out_valid=1, out_code=2, out_last=1 held stable; in_ready=0; a second in_valid is not accepted; the beat completes when out_ready=1.
// - in_vec=4'b0000 -> ZERO_DROP=1: zero_err high exactly 1 cycle, out_valid never rises; ZERO_DROP=0: one beat, code 0, out_last=1, plus the zero_err pulse.
// - in_vec=4'b1111, out_ready toggling 1,0,1,0... -> codes 0,1,2,3, each held through its stall cycle; pend_cnt 4,3,2,1.
// - Pull rst_n low after the first beat of 4'b0110 -> out_valid=0 immediately. After release, in_vec=4'b0010 yields a single code 1 with out_last=1.
// - Scoreboard check on every test: the 2-to-4 decode of each emitted code is a subset of the accepted vector, with no duplicates.

Source files
------------

// File: rtl/enc4to2_seq.sv
// rtl/enc4to2_seq.sv - sequential 4-to-2 encoder, one index beat per set request bit
module enc4to2_seq #(
  parameter logic MSB_FIRST = 1'b0,
  parameter logic ZERO_DROP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_vec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_code,
  output logic       out_last,
  output logic [2:0] pend_cnt,
  output logic       zero_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic       zero_beat_q, zero_beat_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [1:0] out_code_q, out_code_d;
  logic       out_last_q, out_last_d;
  logic [2:0] pend_cnt_q, pend_cnt_d;
  logic       zero_err_q, zero_err_d;

  // Last match wins, so the scan direction picks the lowest or highest set bit.
  function automatic logic [1:0] sel_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 4; i++) if (v[i]) r = i[1:0];
    end else begin
      for (int i = 3; i >= 0; i--) if (v[i]) r = i[1:0];
    end
    return r;
  endfunction

  function automatic logic [2:0] popcnt(input logic [3:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 4; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    zero_beat_d = zero_beat_q;
    zero_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (in_vec != 4'd0) begin
            pend_d  = in_vec;
            state_d = EMIT;
          end else begin
            zero_err_d = 1'b1;
            if (!ZERO_DROP) begin
              zero_beat_d = 1'b1;
              state_d     = EMIT;
            end
          end
        end
      end
      EMIT: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            pend_d      = 4'd0;
            zero_beat_d = 1'b0;
          end else begin
            pend_d = pend_q & ~(4'b0001 << sel_idx(pend_q));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == EMIT);
    out_code_d  = zero_beat_d ? 2'd0 : sel_idx(pend_d);
    pend_cnt_d  = zero_beat_d ? 3'd1 : popcnt(pend_d);
    out_last_d  = (pend_cnt_d == 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= 4'd0;
      zero_beat_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= 2'd0;
      out_last_q  <= 1'b0;
      pend_cnt_q  <= 3'd0;
      zero_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      zero_beat_q <= zero_beat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_last_q  <= out_last_d;
      pend_cnt_q  <= pend_cnt_d;
      zero_err_q  <= zero_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_last  = out_last_q;
  assign pend_cnt  = pend_cnt_q;
  assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_enc4to2_seq.sv
// tb/tb_enc4to2_seq.sv - bench for enc4to2_seq across MSB_FIRST/ZERO_DROP variants
module tb_enc4to2_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_vec = 4'd0;
  logic [2:0] ir, ov, ol, ze;
  logic [5:0] oc;
  logic [8:0] pc;

  // u0: LSB-first drop-zero, u1: MSB-first drop-zero, u2: LSB-first zero-beat
  localparam logic [2:0] MSB = 3'b010;
  localparam logic [2:0] ZD  = 3'b011;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    enc4to2_seq #(.MSB_FIRST(MSB[g]), .ZERO_DROP(ZD[g])) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(ir[g]), .in_vec(in_vec),
      .out_valid(ov[g]), .out_ready(out_ready),
      .out_code(oc[2*g +: 2]), .out_last(ol[g]),
      .pend_cnt(pc[3*g +: 3]), .zero_err(ze[g])
    );
  end

  int checks = 0;
  int errors = 0;

  logic [3:0] rem [3];
  logic [3:0] acc [3];
  logic       zb [3];
  logic       mrdy [3];
  logic       zerr [3];
  int         zcnt [3];
  int         lc0 [$];
  int         lc1 [$];
  int         lc2 [$];
  int         lp0 [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic busy(input int i);
    return zb[i] || (rem[i] != 4'd0);
  endfunction

  function automatic int front(input int i);
    int r;
    r = -1;
    for (int b = 0; b < 4; b++) begin
      if (rem[i][b] && (r < 0 || MSB[i])) r = b;
    end
    return (r < 0) ? 0 : r;
  endfunction

  function automatic int exp_code(input int i);
    return zb[i] ? 0 : front(i);
  endfunction

  function automatic int exp_cnt(input int i);
    return zb[i] ? 1 : $countones(rem[i]);
  endfunction

  function automatic logic all_ready();
    return mrdy[0] && mrdy[1] && mrdy[2];
  endfunction

  function automatic logic any_busy();
    return busy(0) || busy(1) || busy(2);
  endfunction

  task automatic model_loop();
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          rem[i] = 4'd0; acc[i] = 4'd0; zb[i] = 1'b0; mrdy[i] = 1'b0; zerr[i] = 1'b0;
        end else begin
          logic take;
          take = mrdy[i] && in_valid;
          if (busy(i) && out_ready) begin
            if (zb[i]) zb[i] = 1'b0;
            else rem[i][front(i)] = 1'b0;
          end
          zerr[i] = 1'b0;
          if (take) begin
            acc[i]  = in_vec;
            zerr[i] = (in_vec == 4'd0);
            if (in_vec != 4'd0) rem[i] = in_vec;
            else if (!ZD[i]) zb[i] = 1'b1;
          end
          mrdy[i] = !busy(i);
        end
      end
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int code;
        code = int'(oc[2*i +: 2]);
        if (!rst_n) begin
          chk($sformatf("u%0d reset outputs", i),
              int'({ir[i], ov[i], ol[i], ze[i], oc[2*i +: 2], pc[3*i +: 3]}), 0);
        end else begin
          chk($sformatf("u%0d out_valid", i), int'(ov[i]), int'(busy(i)));
          chk($sformatf("u%0d in_ready", i), int'(ir[i]), int'(mrdy[i]));
          chk($sformatf("u%0d zero_err", i), int'(ze[i]), int'(zerr[i]));
          if (ze[i]) zcnt[i]++;
          if (busy(i)) begin
            chk($sformatf("u%0d out_code", i), code, exp_code(i));
            chk($sformatf("u%0d pend_cnt", i), int'(pc[3*i +: 3]), exp_cnt(i));
            chk($sformatf("u%0d out_last", i), int'(ol[i]), int'(exp_cnt(i) == 1));
            chk($sformatf("u%0d code subset/nodup", i), 1,
                int'(zb[i] ? (code == 0) : (acc[i][code] && rem[i][code])));
            if (out_ready) begin
              if (i == 0) begin lc0.push_back(code); lp0.push_back(int'(pc[2:0])); end
              if (i == 1) lc1.push_back(code);
              if (i == 2) lc2.push_back(code);
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    lc0.delete(); lc1.delete(); lc2.delete(); lp0.delete();
    for (int i = 0; i < 3; i++) zcnt[i] = 0;
  endtask

  task automatic send(input logic [3:0] v);
    int n;
    n = 0;
    while (!all_ready() && n < 100) begin tick(); n++; end
    if (n >= 100) chk("send timeout", 1, 0);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (any_busy() && n < 100) begin tick(); n++; end
    if (n >= 100) chk("idle timeout", 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rem[i] = 4'd0; acc[i] = 4'd0; zb[i] = 1'b0; mrdy[i] = 1'b0; zerr[i] = 1'b0; zcnt[i] = 0;
    end
    fork
      model_loop();
      cmp_loop();
    join_none

    repeat (2) tick();
    rst_n = 1'b1;
    chk("in_ready before first edge", int'(ir), 0);
    tick();
    chk("in_ready after first edge", int'(ir), 7);

    out_ready = 1'b1;
    clr_logs();
    send(4'b1011);
    wait_idle();
    chk("1011 lsb beats", lc0.size(), 3);
    chk("1011 lsb code0", lc0[0], 0);
    chk("1011 lsb code1", lc0[1], 1);
    chk("1011 lsb code2", lc0[2], 3);
    chk("1011 pend_cnt seq", lp0[0] * 100 + lp0[1] * 10 + lp0[2], 321);
    chk("1011 msb beats", lc1.size(), 3);
    chk("1011 msb seq", lc1[0] * 100 + lc1[1] * 10 + lc1[2], 310);

    out_ready = 1'b0;
    clr_logs();
    send(4'b0100);
    for (int k = 0; k < 5; k++) begin
      chk("stall out_code", int'(oc[1:0]), 2);
      chk("stall out_last", int'(ol[0]), 1);
      chk("stall in_ready", int'(ir[0]), 0);
      in_valid = 1'b1;
      in_vec   = 4'b1000;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (3) tick();
    chk("stall beats", lc0.size(), 1);
    chk("stall code", lc0[0], 2);
    chk("second vector not taken", int'(ov), 0);

    clr_logs();
    send(4'b0000);
    wait_idle();
    repeat (3) tick();
    chk("zero drop pulses", zcnt[0], 1);
    chk("zero drop beats", lc0.size(), 0);
    chk("zero beat pulses", zcnt[2], 1);
    chk("zero beat beats", lc2.size(), 1);
    chk("zero beat code", lc2[0], 0);

    out_ready = 1'b0;
    clr_logs();
    send(4'b1111);
    for (int k = 0; k < 40 && any_busy(); k++) begin
      out_ready = k[0];
      tick();
    end
    out_ready = 1'b1;
    chk("1111 beats", lc0.size(), 4);
    chk("1111 codes", lc0[0] * 1000 + lc0[1] * 100 + lc0[2] * 10 + lc0[3], 123);
    chk("1111 pend_cnt", lp0[0] * 1000 + lp0[1] * 100 + lp0[2] * 10 + lp0[3], 4321);

    send(4'b0110);
    chk("0110 first code", int'(oc[1:0]), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", int'(ov), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clr_logs();
    send(4'b0010);
    chk("0010 code", int'(oc[1:0]), 1);
    chk("0010 last", int'(ol[0]), 1);
    wait_idle();
    tick();
    chk("0010 beats", lc0.size(), 1);
    chk("0010 logged code", lc0[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
